// File: rtl/pow2_clock_div_ctrl.sv
// rtl/pow2_clock_div_ctrl.sv - runtime power-of-two clock-enable generator with boundary-aligned ratio changes
// Optional clock gating is enabled by defining POW2_DIV_CTRL_GATE_EN.
module pow2_clock_div_ctrl #(
    parameter int MAX_LOG2   = 4,
    parameter int RESET_LOG2 = 2,
    parameter int LOG2_W     = $clog2(MAX_LOG2 + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_cfg_valid,
    input  logic [LOG2_W-1:0] io_cfg_log2,
    output logic              io_cfg_ready,
    output logic              io_clk_en,
    output logic              io_phase,
    output logic [LOG2_W-1:0] io_cur_log2,
    output logic              io_busy,
`ifdef POW2_DIV_CTRL_GATE_EN
    input  logic              io_gate_req,
    output logic              io_gated,
`endif
    output logic              io_cfg_clamped
);

    localparam logic [LOG2_W-1:0] MAX_K = LOG2_W'(MAX_LOG2);
    localparam logic [LOG2_W-1:0] RST_K = LOG2_W'(RESET_LOG2);

`ifdef POW2_DIV_CTRL_GATE_EN
    typedef enum logic [1:0] {RUN, PEND, GATED} state_t;
`else
    typedef enum logic [0:0] {RUN, PEND} state_t;
`endif

    state_t                state;
    logic [MAX_LOG2-1:0]   cnt;
    logic [MAX_LOG2-1:0]   mask;
    logic [LOG2_W-1:0]     cur;
    logic [LOG2_W-1:0]     nxt;
    logic [LOG2_W-1:0]     req_k;
    logic                  req_over;
    logic                  clamped;
    logic                  tc;
    logic                  phase_lvl;
    logic                  accept;
    logic                  gated;

    // Counter bits at or above cur stay zero, so tc is an exact compare to the mask.
    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LOG2; i++) begin
            if (LOG2_W'(i) < cur) mask[i] = 1'b1;
        end
    end

    always_comb begin
        phase_lvl = 1'b1;
        for (int i = 0; i < MAX_LOG2; i++) begin
            if (cur == LOG2_W'(i + 1)) phase_lvl = ~cnt[i];
        end
    end

    assign tc       = (cnt == mask);
    assign req_over = (io_cfg_log2 > MAX_K);
    assign req_k    = req_over ? MAX_K : io_cfg_log2;
    assign accept   = io_cfg_valid && io_cfg_ready;

`ifdef POW2_DIV_CTRL_GATE_EN
    assign gated    = (state == GATED);
    assign io_gated = gated;
`else
    assign gated    = 1'b0;
`endif

    assign io_cfg_ready   = (state == RUN);
    assign io_busy        = (state == PEND);
    assign io_clk_en      = tc && !gated;
    assign io_phase       = phase_lvl && !gated;
    assign io_cur_log2    = cur;
    assign io_cfg_clamped = clamped;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            cur     <= RST_K;
            nxt     <= RST_K;
            state   <= RUN;
            clamped <= 1'b0;
        end else begin
            cnt <= tc ? '0 : cnt + 1'b1;
            if (accept && req_over) clamped <= 1'b1;
            case (state)
                RUN: begin
                    if (accept && (req_k != cur)) begin
                        nxt   <= req_k;
                        state <= PEND;
                    end
`ifdef POW2_DIV_CTRL_GATE_EN
                    else if (io_gate_req && tc) begin
                        cnt   <= '0;
                        state <= GATED;
                    end
`endif
                end
                PEND: begin
                    // tc also wraps cnt to 0, so the new ratio starts a clean period.
                    if (tc) begin
                        cur   <= nxt;
                        state <= RUN;
                    end
                end
`ifdef POW2_DIV_CTRL_GATE_EN
                GATED: begin
                    cnt <= '0;
                    if (!io_gate_req) state <= RUN;
                end
`endif
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pow2_clock_div_ctrl.sv
// tb/tb_pow2_clock_div_ctrl.sv - directed scoreboard bench for pow2_clock_div_ctrl
module tb_pow2_clock_div_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       io_cfg_valid = 1'b0;
    logic [2:0] io_cfg_log2 = 3'd0;
    logic       io_cfg_ready;
    logic       io_clk_en;
    logic       io_phase;
    logic [2:0] io_cur_log2;
    logic       io_busy;
    logic       io_cfg_clamped;

    pow2_clock_div_ctrl #(.MAX_LOG2(4), .RESET_LOG2(2)) dut (
        .clock          (clock),
        .reset          (reset),
        .io_cfg_valid   (io_cfg_valid),
        .io_cfg_log2    (io_cfg_log2),
        .io_cfg_ready   (io_cfg_ready),
        .io_clk_en      (io_clk_en),
        .io_phase       (io_phase),
        .io_cur_log2    (io_cur_log2),
        .io_busy        (io_busy),
        .io_cfg_clamped (io_cfg_clamped)
    );

    always #5 clock = ~clock;

    typedef struct {
        string      tag;
        logic [7:0] v;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;

    // Expected outputs for n cycles of a period of 2^k starting at count c0.
    task automatic push_seq(input string tag, input int k, input int c0, input int n,
                            input logic busy, input logic rdy, input logic clm);
        exp_t e;
        int   c;
        logic en, ph;
        for (int i = 0; i < n; i++) begin
            c  = (c0 + i) % (1 << k);
            en = (c == (1 << k) - 1);
            ph = (k == 0) ? 1'b1 : (c < (1 << (k - 1)));
            e.tag = tag;
            e.v   = {en, ph, 3'(k), busy, rdy, clm};
            q.push_back(e);
        end
    endtask

    task automatic check_pop();
        exp_t       e;
        logic [7:0] obs;
        e   = q.pop_front();
        obs = {io_clk_en, io_phase, io_cur_log2, io_busy, io_cfg_ready, io_cfg_clamped};
        checks++;
        assert (obs === e.v) passed++;
        else $error("FAIL %s en/ph/cur/busy/rdy/clm observed=%b expected=%b", e.tag, obs, e.v);
    endtask

    task automatic drain();
        while (q.size() > 0) begin
            @(negedge clock);
            check_pop();
        end
    endtask

    initial begin
        push_seq("reset", 2, 0, 1, 0, 1, 0);
        drain();
        reset = 1'b0;
        push_seq("default", 2, 1, 8, 0, 1, 0);
        push_seq("pre_mid", 2, 1, 1, 0, 1, 0);
        drain();

        // Mid-period 2 -> 3; data changes during PEND must be ignored.
        io_cfg_valid = 1'b1;
        io_cfg_log2  = 3'd3;
        push_seq("mid_pend", 2, 2, 1, 1, 0, 0);
        drain();
        io_cfg_log2 = 3'd1;
        push_seq("mid_pend_ign", 2, 3, 1, 1, 0, 0);
        drain();
        io_cfg_valid = 1'b0;
        push_seq("k3", 3, 0, 16, 0, 1, 0);
        drain();

        // Request on a tc cycle, 3 -> 2: one full old period first.
        io_cfg_valid = 1'b1;
        io_cfg_log2  = 3'd2;
        push_seq("tc32_pend", 3, 0, 1, 1, 0, 0);
        drain();
        io_cfg_valid = 1'b0;
        push_seq("tc32_pend", 3, 1, 7, 1, 0, 0);
        push_seq("k2", 2, 0, 4, 0, 1, 0);
        drain();

        // Request on a tc cycle, 2 -> 0.
        io_cfg_valid = 1'b1;
        io_cfg_log2  = 3'd0;
        push_seq("tc20_pend", 2, 0, 1, 1, 0, 0);
        drain();
        io_cfg_valid = 1'b0;
        push_seq("tc20_pend", 2, 1, 3, 1, 0, 0);
        push_seq("k0", 0, 0, 4, 0, 1, 0);
        drain();

        // Back to 2 from 0: applied on the very next tc.
        io_cfg_valid = 1'b1;
        io_cfg_log2  = 3'd2;
        push_seq("p02", 0, 0, 1, 1, 0, 0);
        drain();
        io_cfg_valid = 1'b0;
        push_seq("k2b", 2, 0, 2, 0, 1, 0);
        drain();

        // Same-value request completes with no busy.
        io_cfg_valid = 1'b1;
        io_cfg_log2  = 3'd2;
        push_seq("same", 2, 2, 1, 0, 1, 0);
        drain();
        io_cfg_valid = 1'b0;
        push_seq("same_after", 2, 3, 1, 0, 1, 0);
        drain();

        // Over-range request clamps to 4 and sets the sticky flag.
        io_cfg_valid = 1'b1;
        io_cfg_log2  = 3'd7;
        push_seq("clamp_pend", 2, 0, 1, 1, 0, 1);
        drain();
        io_cfg_valid = 1'b0;
        push_seq("clamp_pend", 2, 1, 3, 1, 0, 1);
        push_seq("k4", 4, 0, 20, 0, 1, 1);
        drain();

        // 4 -> 2, then start 2 -> 4 and reset in the middle of PEND.
        io_cfg_valid = 1'b1;
        io_cfg_log2  = 3'd2;
        push_seq("r42_pend", 4, 4, 1, 1, 0, 1);
        drain();
        io_cfg_valid = 1'b0;
        push_seq("r42_pend", 4, 5, 11, 1, 0, 1);
        push_seq("k2c", 2, 0, 2, 0, 1, 1);
        drain();
        io_cfg_valid = 1'b1;
        io_cfg_log2  = 3'd4;
        push_seq("p24", 2, 2, 1, 1, 0, 1);
        drain();
        io_cfg_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        push_seq("async_rst", 2, 0, 1, 0, 1, 0);
        check_pop();
        push_seq("rst_hold", 2, 0, 1, 0, 1, 0);
        drain();
        reset = 1'b0;
        push_seq("post_rst", 2, 1, 12, 0, 1, 0);
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
